aib_axi_leader_wr_tx: RTL and testbench

AIB_AXI_LEADER_WR_TX -- requirements
Module: aib_axi_leader_wr_tx

---
 rtl/aib_axi_pkg.sv | 28 ++
 rtl/aib_axi_sync_fifo.sv | 64 ++++++
 rtl/aib_axi_leader_wr_tx.sv | 182 ++++++++++++++++++
 tb/tb_aib_axi_leader_wr_tx.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aib_axi_pkg.sv
// aib_axi_pkg
// Shared definitions for the AIB AXI leader write path: the link flit
// layout (width, type field, parity bit), flit type codes, the B response
// FIFO depth and the write-transmit FSM state encoding.
package aib_axi_pkg;

  localparam int FLIT_W          = 162;
  localparam int FLIT_TYPE_MSB   = 161;
  localparam int FLIT_TYPE_LSB   = 160;
  localparam int FLIT_PARITY_BIT = 159;

  // DATA payload occupies [DATA_W-1:0] = {wlast, wstrb[15:0], wdata[127:0]}
  localparam int DATA_W          = 145;

  localparam logic [1:0] FLIT_IDLE = 2'b00;
  localparam logic [1:0] FLIT_HDR  = 2'b01;
  localparam logic [1:0] FLIT_DATA = 2'b10;

  localparam logic [7:0] CREDIT_MAX   = 8'hFF;
  localparam int         B_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } wr_state_e;

endpackage

// File: rtl/aib_axi_sync_fifo.sv
// aib_axi_sync_fifo
// Single-clock FIFO with drop-on-full. A push to a full FIFO is discarded
// and flagged on 'drop' for that cycle, unless a pop happens in the same
// cycle, in which case both succeed. 'rdata' shows the head entry (zero
// while empty).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write request and data
//   pop             read request (ignored while empty)
//   rdata, empty    head entry, empty status
//   drop            push discarded this cycle
module aib_axi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/aib_axi_leader_wr_tx.sv
// aib_axi_leader_wr_tx
// AXI write slave that serialises AW/W traffic onto a credit-flow-controlled
// link as one HDR flit followed by awlen+1 DATA flits, and returns B
// responses received from the link through a small FIFO.
// Ports:
//   clk_wr, rst_wr          clock, asynchronous active-high reset
//   init_w_credit           credit count loaded while in reset
//   s_axi_aw*               AXI write address channel
//   s_axi_w*                AXI write data channel
//   s_axi_b*                AXI write response channel
//   tx_data, tx_valid       outgoing link flit (no backpressure)
//   rx_credit_ret           far end released one flit buffer
//   rx_b_valid/id/resp      B response received from the link
//   err_flags               sticky {B FIFO overflow, credit overflow, wlast mismatch}
// Build option: AIB_AXI_LDR_PARITY_EN puts even parity into tx_data[159].
//
// state | meaning
// IDLE  | waiting for an AW handshake
// HDR   | header latched, waiting for a credit to send the HDR flit
// DATA  | forwarding W beats, one credit each, until beat == awlen
module aib_axi_leader_wr_tx
  import aib_axi_pkg::*;
#(
  parameter int ADDRWIDTH = 32,
  parameter int IDWIDTH   = 4
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr,
  input  logic [7:0]           init_w_credit,
  input  logic [IDWIDTH-1:0]   s_axi_awid,
  input  logic [ADDRWIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]           s_axi_awlen,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [127:0]         s_axi_wdata,
  input  logic [15:0]          s_axi_wstrb,
  input  logic                 s_axi_wlast,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [IDWIDTH-1:0]   s_axi_bid,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  output logic [FLIT_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic                 rx_credit_ret,
  input  logic                 rx_b_valid,
  input  logic [IDWIDTH-1:0]   rx_b_id,
  input  logic [1:0]           rx_b_resp,
  output logic [2:0]           err_flags
);

  localparam int HDR_W = 8 + ADDRWIDTH + IDWIDTH;

  wr_state_e            state_q, state_d;
  logic [IDWIDTH-1:0]   id_q;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [7:0]           len_q;
  logic [7:0]           beat_q;
  logic [7:0]           credit_q, credit_d;
  logic                 credit_ovf;
  logic                 data_vld_q;
  logic [DATA_W-1:0]    data_q;
  logic [2:0]           err_q;

  logic aw_hs, w_hs, hdr_send, consume, beat_last;
  logic fifo_empty, fifo_drop;
  logic [IDWIDTH+1:0] fifo_rdata;

  assign beat_last = (beat_q == len_q);

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    // awready is masked during reset so no ready/valid output is high there.
    s_axi_awready = (state_q == IDLE) && !rst_wr;
    s_axi_wready  = (state_q == DATA) && (credit_q != 8'd0);
    hdr_send      = (state_q == HDR) && (credit_q != 8'd0);
    aw_hs         = s_axi_awready && s_axi_awvalid;
    w_hs          = s_axi_wready && s_axi_wvalid;
    case (state_q)
      IDLE:    if (aw_hs) state_d = HDR;
      HDR:     if (hdr_send) state_d = DATA;
      DATA:    if (w_hs && beat_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A return and a consume in the same cycle cancel out; a lone return at
  // the maximum is dropped and reported.
  always_comb begin
    credit_d   = credit_q;
    credit_ovf = 1'b0;
    consume    = hdr_send || w_hs;
    if (rx_credit_ret && !consume) begin
      if (credit_q == CREDIT_MAX) credit_ovf = 1'b1;
      else                        credit_d   = credit_q + 8'd1;
    end else if (consume && !rx_credit_ret) begin
      credit_d = credit_q - 8'd1;
    end
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      credit_q   <= init_w_credit;
      data_vld_q <= 1'b0;
      data_q     <= '0;
      err_q      <= '0;
    end else begin
      credit_q   <= credit_d;
      data_vld_q <= w_hs;
      if (aw_hs) begin
        id_q   <= s_axi_awid;
        addr_q <= s_axi_awaddr;
        len_q  <= s_axi_awlen;
        beat_q <= '0;
      end
      if (w_hs) begin
        // The flit's wlast comes from awlen, not from the master.
        data_q <= {beat_last, s_axi_wstrb, s_axi_wdata};
        beat_q <= beat_q + 8'd1;
        if (s_axi_wlast != beat_last) err_q[0] <= 1'b1;
      end else begin
        data_q <= '0;
      end
      if (credit_ovf) err_q[1] <= 1'b1;
      if (fifo_drop)  err_q[2] <= 1'b1;
    end
  end

  assign err_flags = err_q;

  // The HDR flit is driven straight from the HDR state so it appears the
  // cycle after the AW handshake; DATA flits come from the beat register.
  // The two cannot overlap: the last DATA flit is emitted while in IDLE.
  always_comb begin
    tx_data  = '0;
    tx_valid = hdr_send || data_vld_q;
    tx_data[FLIT_TYPE_MSB:FLIT_TYPE_LSB] = FLIT_IDLE;
    if (hdr_send) begin
      tx_data[FLIT_TYPE_MSB:FLIT_TYPE_LSB] = FLIT_HDR;
      tx_data[HDR_W-1:0]                   = {len_q, addr_q, id_q};
    end else if (data_vld_q) begin
      tx_data[FLIT_TYPE_MSB:FLIT_TYPE_LSB] = FLIT_DATA;
      tx_data[DATA_W-1:0]                  = data_q;
    end
`ifdef AIB_AXI_LDR_PARITY_EN
    if (tx_valid)
      tx_data[FLIT_PARITY_BIT] = ^{tx_data[FLIT_W-1:FLIT_PARITY_BIT+1],
                                   tx_data[FLIT_PARITY_BIT-1:0]};
`else
    tx_data[FLIT_PARITY_BIT] = 1'b0;
`endif
  end

  aib_axi_sync_fifo #(
    .WIDTH (IDWIDTH + 2),
    .DEPTH (B_FIFO_DEPTH)
  ) u_b_fifo (
    .clk   (clk_wr),
    .rst   (rst_wr),
    .push  (rx_b_valid),
    .wdata ({rx_b_id, rx_b_resp}),
    .pop   (s_axi_bvalid && s_axi_bready),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign s_axi_bvalid = !fifo_empty;
  assign s_axi_bid    = fifo_rdata[IDWIDTH+1:2];
  assign s_axi_bresp  = fifo_rdata[1:0];

endmodule

// File: tb/tb_aib_axi_leader_wr_tx.sv
module tb_aib_axi_leader_wr_tx;

  logic         clk_wr = 1'b0;
  logic         rst_wr = 1'b1;
  logic [7:0]   init_w_credit = 8'd8;
  logic [3:0]   s_axi_awid = '0;
  logic [31:0]  s_axi_awaddr = '0;
  logic [7:0]   s_axi_awlen = '0;
  logic         s_axi_awvalid = 1'b0;
  logic         s_axi_awready;
  logic [127:0] s_axi_wdata = '0;
  logic [15:0]  s_axi_wstrb = '0;
  logic         s_axi_wlast = 1'b0;
  logic         s_axi_wvalid = 1'b0;
  logic         s_axi_wready;
  logic [3:0]   s_axi_bid;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready = 1'b0;
  logic [161:0] tx_data;
  logic         tx_valid;
  logic         rx_credit_ret = 1'b0;
  logic         rx_b_valid = 1'b0;
  logic [3:0]   rx_b_id = '0;
  logic [1:0]   rx_b_resp = '0;
  logic [2:0]   err_flags;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int           c;
    logic [161:0] d;
  } flit_t;
  flit_t fq[$];

  aib_axi_leader_wr_tx #(.ADDRWIDTH(32), .IDWIDTH(4)) dut (
    .clk_wr        (clk_wr),
    .rst_wr        (rst_wr),
    .init_w_credit (init_w_credit),
    .s_axi_awid    (s_axi_awid),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bid     (s_axi_bid),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .rx_credit_ret (rx_credit_ret),
    .rx_b_valid    (rx_b_valid),
    .rx_b_id       (rx_b_id),
    .rx_b_resp     (rx_b_resp),
    .err_flags     (err_flags)
  );

  always #5 clk_wr = ~clk_wr;
  always @(posedge clk_wr) cyc++;
  always @(negedge clk_wr) if (tx_valid === 1'b1) fq.push_back('{cyc, tx_data});

  function automatic logic [161:0] add_par(input logic [161:0] f);
    logic [161:0] r;
    r = f;
`ifdef AIB_AXI_LDR_PARITY_EN
    r[159] = ^{r[161:160], r[158:0]};
`endif
    return r;
  endfunction

  function automatic logic [161:0] mk_hdr(input logic [7:0] len, input logic [31:0] a,
                                          input logic [3:0] id);
    logic [161:0] f;
    f = '0;
    f[161:160] = 2'b01;
    f[43:0] = {len, a, id};
    return add_par(f);
  endfunction

  function automatic logic [161:0] mk_data(input logic last, input logic [15:0] strb,
                                           input logic [127:0] d);
    logic [161:0] f;
    f = '0;
    f[161:160] = 2'b10;
    f[144:0] = {last, strb, d};
    return add_par(f);
  endfunction

  task automatic do_reset(input logic [7:0] cr);
    s_axi_awvalid = 0; s_axi_wvalid = 0; rx_credit_ret = 0; rx_b_valid = 0; s_axi_bready = 0;
    init_w_credit = cr;
    rst_wr = 1;
    repeat (2) @(posedge clk_wr);
    #1 rst_wr = 0;
    fq.delete();
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         output int hs);
    bit got;
    got = 0; hs = -1;
    s_axi_awid = id; s_axi_awaddr = a; s_axi_awlen = len; s_axi_awvalid = 1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_wr);
      if (s_axi_awready === 1'b1) begin got = 1; hs = cyc; end
    end
    @(posedge clk_wr); #1;
    s_axi_awvalid = 0;
    total++;
    if (!got) begin bad++; $display("FAIL aw_handshake timed out"); end
  endtask

  task automatic send_w(input logic [127:0] d, input logic [15:0] strb, input logic last,
                        output int hs);
    bit got;
    got = 0; hs = -1;
    s_axi_wdata = d; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_wr);
      if (s_axi_wready === 1'b1) begin got = 1; hs = cyc; end
    end
    @(posedge clk_wr); #1;
    s_axi_wvalid = 0;
    total++;
    if (!got) begin bad++; $display("FAIL w_handshake timed out"); end
  endtask

  task automatic test_reset;
    rst_wr = 1; init_w_credit = 8'd8;
    @(negedge clk_wr);
    total++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, tx_valid} !== 4'b0000 ||
        tx_data !== '0 || err_flags !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs got aw=%b w=%b b=%b txv=%b tx=%h err=%b required all zero",
               s_axi_awready, s_axi_wready, s_axi_bvalid, tx_valid, tx_data, err_flags);
    end
    total++;
    if (dut.credit_q !== 8'd8) begin
      bad++; $display("FAIL reset_credit got %0d required 8", dut.credit_q);
    end
  endtask

  task automatic test_basic_burst;
    int ha;
    int hw[4];
    logic [161:0] exp;
    do_reset(8'd8);
    send_aw(4'd2, 32'h0000_1000, 8'd3, ha);
    for (int i = 0; i < 4; i++)
      send_w({4{32'hA500_0000 | i}}, 16'hF0F0 ^ 16'(i), (i == 3), hw[i]);
    repeat (3) @(posedge clk_wr); #1;
    total++;
    if (fq.size() != 5) begin
      bad++; $display("FAIL burst_flit_count got %0d required 5", fq.size());
    end else begin
      exp = mk_hdr(8'd3, 32'h0000_1000, 4'd2);
      total++;
      if (fq[0].d !== exp || fq[0].c != ha + 1) begin
        bad++; $display("FAIL burst_hdr got %h@%0d required %h@%0d", fq[0].d, fq[0].c, exp, ha + 1);
      end
      for (int i = 0; i < 4; i++) begin
        exp = mk_data((i == 3), 16'hF0F0 ^ 16'(i), {4{32'hA500_0000 | i}});
        total++;
        if (fq[i+1].d !== exp || fq[i+1].c != hw[i] + 1) begin
          bad++; $display("FAIL burst_data%0d got %h@%0d required %h@%0d",
                          i, fq[i+1].d, fq[i+1].c, exp, hw[i] + 1);
        end
      end
    end
    total++;
    if (dut.credit_q !== 8'd3) begin
      bad++; $display("FAIL burst_credit got %0d required 3", dut.credit_q);
    end
    total++;
    if (err_flags !== 3'b000) begin
      bad++; $display("FAIL burst_err got %b required 000", err_flags);
    end
  endtask

  task automatic test_credit_stall;
    int ha, hw, pc, early;
    logic [161:0] exp;
    do_reset(8'd1);
    send_aw(4'd5, 32'h2000_0040, 8'd0, ha);
    s_axi_wdata = {4{32'h1234_5678}}; s_axi_wstrb = 16'hFFFF; s_axi_wlast = 1; s_axi_wvalid = 1;
    early = 0;
    repeat (4) begin
      @(negedge clk_wr);
      if (s_axi_wready !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++; $display("FAIL stall_wready got %0d ready cycles required 0", early);
    end
    @(posedge clk_wr); #1 rx_credit_ret = 1; pc = cyc;
    @(posedge clk_wr); #1 rx_credit_ret = 0;
    send_w({4{32'h1234_5678}}, 16'hFFFF, 1'b1, hw);
    total++;
    if (hw != pc + 1) begin
      bad++; $display("FAIL stall_release got hs@%0d required hs@%0d", hw, pc + 1);
    end
    repeat (2) @(posedge clk_wr); #1;
    total++;
    if (fq.size() != 2) begin
      bad++; $display("FAIL stall_flit_count got %0d required 2", fq.size());
    end else begin
      exp = mk_hdr(8'd0, 32'h2000_0040, 4'd5);
      total++;
      if (fq[0].d !== exp || fq[0].c != ha + 1) begin
        bad++; $display("FAIL stall_hdr got %h@%0d required %h@%0d", fq[0].d, fq[0].c, exp, ha + 1);
      end
      exp = mk_data(1'b1, 16'hFFFF, {4{32'h1234_5678}});
      total++;
      if (fq[1].d !== exp || fq[1].c != hw + 1) begin
        bad++; $display("FAIL stall_data got %h@%0d required %h@%0d", fq[1].d, fq[1].c, exp, hw + 1);
      end
    end
    total++;
    if (dut.credit_q !== 8'd0) begin
      bad++; $display("FAIL stall_credit got %0d required 0", dut.credit_q);
    end
  endtask

  task automatic test_wlast_mismatch;
    int ha, h0, h1;
    logic [161:0] exp;
    do_reset(8'd8);
    send_aw(4'd1, 32'h0000_3000, 8'd1, ha);
    send_w({4{32'hDEAD_0000}}, 16'h00FF, 1'b1, h0);
    total++;
    if (err_flags !== 3'b001) begin
      bad++; $display("FAIL wlast_err got %b required 001", err_flags);
    end
    send_w({4{32'hDEAD_0001}}, 16'hFF00, 1'b1, h1);
    repeat (2) @(posedge clk_wr); #1;
    total++;
    if (fq.size() != 3) begin
      bad++; $display("FAIL wlast_flit_count got %0d required 3", fq.size());
    end else begin
      exp = mk_data(1'b0, 16'h00FF, {4{32'hDEAD_0000}});
      total++;
      if (fq[1].d !== exp) begin
        bad++; $display("FAIL wlast_beat0 got %h required %h", fq[1].d, exp);
      end
      exp = mk_data(1'b1, 16'hFF00, {4{32'hDEAD_0001}});
      total++;
      if (fq[2].d !== exp) begin
        bad++; $display("FAIL wlast_beat1 got %h required %h", fq[2].d, exp);
      end
    end
  endtask

  task automatic test_credit_boundary;
    int ha, hw;
    do_reset(8'd255);
    send_aw(4'd3, 32'h0000_0100, 8'd0, ha);
    rx_credit_ret = 1;
    @(posedge clk_wr); #1 rx_credit_ret = 0;
    total++;
    if (dut.credit_q !== 8'd255 || err_flags !== 3'b000) begin
      bad++; $display("FAIL credit_same_cycle got credit=%0d err=%b required 255 000",
                      dut.credit_q, err_flags);
    end
    send_w({4{32'h0}}, 16'h0001, 1'b1, hw);
    total++;
    if (dut.credit_q !== 8'd254) begin
      bad++; $display("FAIL credit_consume got %0d required 254", dut.credit_q);
    end
    rx_credit_ret = 1;
    @(posedge clk_wr); #1 rx_credit_ret = 0;
    total++;
    if (dut.credit_q !== 8'd255 || err_flags !== 3'b000) begin
      bad++; $display("FAIL credit_return got credit=%0d err=%b required 255 000",
                      dut.credit_q, err_flags);
    end
    do_reset(8'd255);
    rx_credit_ret = 1;
    @(posedge clk_wr); #1 rx_credit_ret = 0;
    total++;
    if (dut.credit_q !== 8'd255 || err_flags !== 3'b010) begin
      bad++; $display("FAIL credit_overflow got credit=%0d err=%b required 255 010",
                      dut.credit_q, err_flags);
    end
  endtask

  task automatic test_b_fifo;
    logic [3:0] eid [4];
    logic [1:0] ers [4];
    eid = '{4'd2, 4'd3, 4'd4, 4'd6};
    ers = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_reset(8'd8);
    for (int i = 0; i < 5; i++) begin
      rx_b_valid = 1; rx_b_id = 4'(i + 1); rx_b_resp = 2'(i);
      @(posedge clk_wr); #1;
    end
    rx_b_valid = 0;
    total++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bid !== 4'd1 || err_flags !== 3'b100) begin
      bad++; $display("FAIL bfifo_full got bvalid=%b bid=%0d err=%b required 1 1 100",
                      s_axi_bvalid, s_axi_bid, err_flags);
    end
    rx_b_valid = 1; rx_b_id = 4'd6; rx_b_resp = 2'd3; s_axi_bready = 1;
    @(posedge clk_wr); #1;
    rx_b_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_wr);
      total++;
      if (s_axi_bvalid !== 1'b1 || s_axi_bid !== eid[k] || s_axi_bresp !== ers[k]) begin
        bad++; $display("FAIL bfifo_pop%0d got v=%b id=%0d resp=%0d required 1 %0d %0d",
                        k, s_axi_bvalid, s_axi_bid, s_axi_bresp, eid[k], ers[k]);
      end
    end
    @(negedge clk_wr);
    total++;
    if (s_axi_bvalid !== 1'b0) begin
      bad++; $display("FAIL bfifo_drained got bvalid=%b required 0", s_axi_bvalid);
    end
    s_axi_bready = 0;
  endtask

  task automatic test_reset_mid_burst;
    int ha, hw, n;
    logic [161:0] exp;
    do_reset(8'd8);
    send_aw(4'd7, 32'h0000_4000, 8'd3, ha);
    send_w({4{32'hB000_0000}}, 16'hFFFF, 1'b0, hw);
    send_w({4{32'hB000_0001}}, 16'hFFFF, 1'b0, hw);
    s_axi_wdata = {4{32'hB000_0002}}; s_axi_wvalid = 1; s_axi_wlast = 0;
    @(negedge clk_wr); #1 rst_wr = 1;
    #1;
    total++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, tx_valid} !== 4'b0000 ||
        tx_data !== '0 || err_flags !== 3'b000 || dut.credit_q !== 8'd8) begin
      bad++; $display("FAIL midreset_outputs got aw=%b w=%b txv=%b tx=%h credit=%0d required zeros/8",
                      s_axi_awready, s_axi_wready, tx_valid, tx_data, dut.credit_q);
    end
    n = fq.size();
    s_axi_wvalid = 0;
    repeat (2) @(posedge clk_wr);
    #1 rst_wr = 0;
    repeat (3) @(posedge clk_wr); #1;
    total++;
    if (fq.size() != n) begin
      bad++; $display("FAIL midreset_no_flits got %0d extra required 0", fq.size() - n);
    end
    fq.delete();
    send_aw(4'd8, 32'h0000_5000, 8'd0, ha);
    send_w({4{32'hC000_0000}}, 16'h0F0F, 1'b1, hw);
    repeat (2) @(posedge clk_wr); #1;
    total++;
    if (fq.size() != 2) begin
      bad++; $display("FAIL midreset_next_count got %0d required 2", fq.size());
    end else begin
      exp = mk_hdr(8'd0, 32'h0000_5000, 4'd8);
      total++;
      if (fq[0].d !== exp || fq[0].c != ha + 1) begin
        bad++; $display("FAIL midreset_next_hdr got %h@%0d required %h@%0d", fq[0].d, fq[0].c, exp, ha + 1);
      end
      exp = mk_data(1'b1, 16'h0F0F, {4{32'hC000_0000}});
      total++;
      if (fq[1].d !== exp || fq[1].c != hw + 1) begin
        bad++; $display("FAIL midreset_next_data got %h@%0d required %h@%0d", fq[1].d, fq[1].c, exp, hw + 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic_burst;
    test_credit_stall;
    test_wlast_mismatch;
    test_credit_boundary;
    test_b_fifo;
    test_reset_mid_burst;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
